// File: rtl/cpu_output_collector.sv
// cpu_output_collector
//   Host-side partner of the CPU output port. It pulses startIO to launch a
//   run, then captures every out_word the CPU publishes (one word per rising
//   edge of outFlag) into a first-word-fall-through FIFO. The run ends once
//   outFlag has stayed quiet for TIMEOUT cycles.
//
//   Ports
//     clock     board clock; all logic runs on the rising edge
//     reset     asynchronous, active-low; clears all state
//     go        launch request, accepted in IDLE and DONE
//     outFlag   CPU output-valid flag (asynchronous to clock)
//     out_word  CPU output data, stable while outFlag is high
//     startIO   launch strobe to the CPU, high START_CYCLES cycles
//     rd_en     pop the FIFO head (ignored when empty)
//     rd_data   FIFO head, valid while empty=0
//     empty/full/count  FIFO status, decoded from the registered count
//     busy      high in START and CAPTURE
//     done      high in DONE
//     overflow  sticky: a word arrived while full and was dropped
module cpu_output_collector #(
  parameter int WIDTH        = 36,
  parameter int DEPTH        = 16,
  parameter int START_CYCLES = 4,
  parameter int TIMEOUT      = 100_000_000
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       go,
  input  logic                       outFlag,
  input  logic [WIDTH-1:0]           out_word,
  output logic                       startIO,
  input  logic                       rd_en,
  output logic [WIDTH-1:0]           rd_data,
  output logic                       empty,
  output logic                       full,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       busy,
  output logic                       done,
  output logic                       overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam int SW = (START_CYCLES > 1) ? $clog2(START_CYCLES) : 1;
  localparam int TW = $clog2(TIMEOUT);

  localparam logic [SW-1:0] S_LAST = SW'(START_CYCLES-1);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT-1);
  localparam logic [CW-1:0] C_FULL = CW'(DEPTH);

  typedef enum logic [1:0] {IDLE, START, CAPTURE, DONE} state_t;

  state_t            state, state_nx;
  logic [SW-1:0]     scnt;
  logic [TW-1:0]     tcnt;

  // outFlag: two-flop synchroniser plus a previous-value flop for edge detect.
  // out_word rides an equal-depth chain so d2 lines up with s2.
  logic              s1, s2, prev;
  logic [WIDTH-1:0]  d1, d2;
  logic              rise;

  logic [WIDTH-1:0]  mem [DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic              push, pop, drop, fifo_clr;

  assign rise     = s2 & ~prev;
  // Push is judged against the pre-pop full, so a same-cycle pop never
  // makes room for a word arriving while full.
  assign push     = (state == CAPTURE) && rise && !full;
  assign drop     = (state == CAPTURE) && rise &&  full;
  assign pop      = rd_en && !empty;
  assign fifo_clr = (state == DONE) && go;

  assign empty    = (count == '0);
  assign full     = (count == C_FULL);
  assign rd_data  = mem[rd_ptr];

  // next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (go) state_nx = START;
      START:   if (scnt == S_LAST) state_nx = CAPTURE;
      CAPTURE: if (!rise && tcnt == T_LAST) state_nx = DONE;
      DONE:    if (go) state_nx = START;
      default: state_nx = IDLE;
    endcase
  end

  // state, counters and registered status outputs
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      scnt    <= '0;
      tcnt    <= '0;
      startIO <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state   <= state_nx;
      scnt    <= (state == START) ? scnt + 1'b1 : '0;
      // held at zero outside CAPTURE, so entry always starts from zero
      tcnt    <= (state != CAPTURE || rise) ? '0 : tcnt + 1'b1;
      // outputs follow the state they will be in after this edge
      startIO <= (state_nx == START);
      busy    <= (state_nx == START) || (state_nx == CAPTURE);
      done    <= (state_nx == DONE);
    end
  end

  // synchronisers run in every state so stale levels never look like edges
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      s1   <= 1'b0;
      s2   <= 1'b0;
      prev <= 1'b0;
      d1   <= '0;
      d2   <= '0;
    end else begin
      s1   <= outFlag;
      s2   <= s1;
      prev <= s2;
      d1   <= out_word;
      d2   <= d1;
    end
  end

  // FIFO pointers, occupancy and sticky overflow
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else if (fifo_clr) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (drop) overflow <= 1'b1;
    end
  end

  // storage needs no reset; occupancy tracks validity
  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= d2;
  end

endmodule

// File: tb/tb_cpu_output_collector.sv
// tb_cpu_output_collector
//   Directed bench for cpu_output_collector with DEPTH=4, START_CYCLES=4,
//   TIMEOUT=50. Inputs change and outputs are sampled on the falling edge.
module tb_cpu_output_collector;

  localparam int WIDTH = 36;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH+1);

  logic             clock, reset, go, outFlag, rd_en;
  logic [WIDTH-1:0] out_word, rd_data;
  logic             startIO, empty, full, busy, done, overflow;
  logic [CW-1:0]    count;

  int checks = 0;
  int errors = 0;
  int highs, busy_lo, waited;

  cpu_output_collector #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .START_CYCLES(4), .TIMEOUT(50)
  ) dut (
    .clock(clock), .reset(reset), .go(go), .outFlag(outFlag),
    .out_word(out_word), .startIO(startIO), .rd_en(rd_en),
    .rd_data(rd_data), .empty(empty), .full(full), .count(count),
    .busy(busy), .done(done), .overflow(overflow)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic pulse(input logic [WIDTH-1:0] w, input int hi, input int lo);
    outFlag  = 1'b1;
    out_word = w;
    step(hi);
    outFlag  = 1'b0;
    step(lo);
  endtask

  task automatic pop1();
    rd_en = 1'b1;
    step(1);
    rd_en = 1'b0;
  endtask

  task automatic launch();
    go = 1'b1;
    step(1);
    go = 1'b0;
  endtask

  task automatic wait_done(output int w);
    w = 0;
    while (!done && w < 300) begin
      step(1);
      w++;
    end
  endtask

  initial begin
    reset = 1'b0; go = 1'b0; outFlag = 1'b0; rd_en = 1'b0; out_word = '0;
    step(2);
    chk("rst_startIO",  startIO,  0);
    chk("rst_empty",    empty,    1);
    chk("rst_full",     full,     0);
    chk("rst_count",    count,    0);
    chk("rst_busy",     busy,     0);
    chk("rst_done",     done,     0);
    chk("rst_overflow", overflow, 0);
    reset = 1'b1;
    step(2);

    // launch with go held high: startIO must pulse once for 4 cycles
    go = 1'b1; highs = 0; busy_lo = 0;
    for (int i = 0; i < 20; i++) begin
      step(1);
      if (startIO) highs++;
      if (!busy) busy_lo++;
    end
    go = 1'b0;
    chk("start_len",     highs,   4);
    chk("start_busy",    busy_lo, 0);
    chk("capture_start", startIO, 0);

    // three captured words, read back in order
    pulse(36'h000000001, 10, 5);
    pulse(36'hABCDEF012, 10, 5);
    pulse(36'hFFFFFFFFF, 10, 5);
    chk("cap_count", count,   3);
    chk("cap_empty", empty,   0);
    chk("cap_head0", rd_data, 36'h000000001);
    pop1();
    chk("cap_head1", rd_data, 36'hABCDEF012);
    chk("cap_cnt2",  count,   2);
    pop1();
    chk("cap_head2", rd_data, 36'hFFFFFFFFF);
    pop1();
    chk("cap_drain", empty,   1);
    chk("cap_notdone", done,  0);
    // last push was 15 edges ago; 50 quiet CAPTURE cycles end the run
    wait_done(waited);
    chk("timeout_wait", waited, 35);
    chk("timeout_done", done,   1);
    chk("timeout_busy", busy,   0);

    // run 2: simultaneous push/pop, then overflow
    launch();
    chk("r2_busy", busy, 1);
    step(4);
    chk("r2_capture", startIO, 0);
    pulse(36'h200, 3, 3);
    pulse(36'h201, 3, 3);
    chk("r2_count2", count, 2);
    chk("r2_head",   rd_data, 36'h200);
    outFlag = 1'b1; out_word = 36'h202;
    step(2);
    rd_en = 1'b1;
    step(1);
    rd_en = 1'b0;
    chk("simul_count", count,    2);
    chk("simul_head",  rd_data,  36'h201);
    chk("simul_ovf",   overflow, 0);
    step(1); outFlag = 1'b0; step(3);
    pulse(36'h203, 3, 3);
    pulse(36'h204, 3, 3);
    chk("r2_full",  full,  1);
    chk("r2_cnt4",  count, 4);
    outFlag = 1'b1; out_word = 36'h205;
    step(2);
    rd_en = 1'b1;
    step(1);
    rd_en = 1'b0;
    chk("fullsim_count", count,    3);
    chk("fullsim_ovf",   overflow, 1);
    chk("fullsim_head",  rd_data,  36'h202);
    step(1); outFlag = 1'b0; step(3);
    pop1();
    chk("drain_head", rd_data, 36'h203);
    pop1(); pop1();
    chk("drain_empty", empty, 1);
    for (int i = 0; i < 6; i++) pulse(36'h100 + 36'(i), 3, 3);
    chk("ovf_count", count,    4);
    chk("ovf_full",  full,     1);
    chk("ovf_flag",  overflow, 1);
    chk("ovf_rd0", rd_data, 36'h100); pop1();
    chk("ovf_rd1", rd_data, 36'h101); pop1();
    chk("ovf_rd2", rd_data, 36'h102); pop1();
    chk("ovf_rd3", rd_data, 36'h103);
    chk("ovf_cnt1", count, 1);
    wait_done(waited);
    chk("r2_done", done, 1);
    launch();
    chk("clr_count", count,    0);
    chk("clr_empty", empty,    1);
    chk("clr_ovf",   overflow, 0);
    chk("clr_start", startIO,  1);

    // run 3: edge during START is ignored
    outFlag = 1'b1; out_word = 36'h55;
    step(2);
    outFlag = 1'b0;
    step(4);
    chk("start_edge_cnt", count,   0);
    chk("start_edge_st",  startIO, 0);
    chk("start_edge_bsy", busy,    1);
    // long level: one push only
    outFlag = 1'b1; out_word = 36'h77;
    step(200);
    chk("level_count", count,   1);
    chk("level_data",  rd_data, 36'h77);
    chk("level_done",  done,    1);
    outFlag = 1'b0;
    step(3);
    pulse(36'h88, 3, 3);
    chk("done_edge_cnt", count, 1);

    // run 4: reset mid-CAPTURE with 3 words stored
    launch();
    step(4);
    pulse(36'h301, 3, 3);
    pulse(36'h302, 3, 3);
    pulse(36'h303, 3, 3);
    chk("r4_count", count, 3);
    #2 reset = 1'b0;
    #1;
    chk("mid_busy",  busy,     0);
    chk("mid_done",  done,     0);
    chk("mid_empty", empty,    1);
    chk("mid_full",  full,     0);
    chk("mid_count", count,    0);
    chk("mid_ovf",   overflow, 0);
    step(1);
    reset = 1'b1;
    step(1);
    chk("post_empty", empty, 1);
    chk("post_busy",  busy,  0);

    // reset during START drops startIO at once
    launch();
    chk("r5_start", startIO, 1);
    #2 reset = 1'b0;
    #1;
    chk("r5_start_drop", startIO, 0);
    chk("r5_busy_drop",  busy,    0);
    step(1);
    reset = 1'b1;
    step(1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cpu_output_collector.md
# cpu_output_collector

Host-side counterpart of the CPU's output interface. It issues the `startIO` pulse that launches a program run, then captures each 36-bit `out` word the CPU publishes with `outFlag` into a FIFO. A host or display reads the FIFO back. It runs on the 50 MHz board clock and synchronises `outFlag`/`out`, which the CPU drives from its divided 1 Hz domain.

## Interface
- WIDTH, 36, data word width (matches CPU `out`)
- DEPTH, 16, FIFO entries (power of two, ≥2)
- START_CYCLES, 4, clock cycles `startIO` is held high per launch (≥1)
- TIMEOUT, 100_000_000, idle clock cycles in CAPTURE before a run is declared finished (≥4)
- clock  in  1  board clock, all logic on rising edge
- reset  in  1  asynchronous, active-low; low clears all state immediately
- go  in  1  host request to launch a run; sampled high for one cycle
- outFlag  in  1  CPU output-valid flag (asynchronous to `clock`)
- out_word  in  WIDTH  CPU output data, stable while `outFlag` high
- startIO  out  1  launch strobe to CPU
- rd_en  in  1  pop head of FIFO
- rd_data  out  WIDTH  FIFO head (first-word-fall-through), valid when `empty`=0
- empty  out  1  FIFO empty
- full  out  1  FIFO full
- count  out  $clog2(DEPTH+1)  FIFO occupancy
- busy  out  1  high in START and CAPTURE
- done  out  1  high in DONE
- overflow  out  1  sticky: a word arrived while full and was dropped

## Operation
- FSM states: IDLE, START, CAPTURE, DONE.
- IDLE: `go`=1 → START. `go` is ignored in START and CAPTURE.
- START: `startIO`=1 for exactly START_CYCLES cycles, then → CAPTURE. The timeout counter is cleared on entry to CAPTURE.
- CAPTURE: on each detected rising edge of synchronised `outFlag`:
  - push the synchronised word if not full;
  - if full, drop the word and set `overflow`;
  - clear the timeout counter in either case.
- CAPTURE: otherwise the timeout counter increments; at TIMEOUT−1 → DONE.
- DONE: `go`=1 → START. In the same cycle the FIFO is cleared (pointers and count to 0) and `overflow` is cleared.
- Synchronisers:
  - `outFlag` passes through 2 flops plus a previous-value flop; rise = s2 & ~prev.
  - `out_word` passes through 2 parallel flops, so the pushed data aligns with s2.
- FIFO:
  - circular with wrapping pointers; `rd_data` = mem[rd_ptr].
  - `rd_en` when empty is ignored.
  - A push and a pop in the same cycle: both take effect and `count` is unchanged. When full, the pop frees no slot for that cycle's push (push is evaluated against the pre-pop `full`).
  - Reads are allowed in every state.
- A level-high `outFlag` produces exactly one push. A new push requires `outFlag` to fall and rise again.
- Edges seen in IDLE, START or DONE are not captured, but they still update the synchroniser.

## Timing
- Reset (async, `reset`=0) values:
  - state IDLE, `startIO`=0;
  - `empty`=1, `full`=0, `count`=0;
  - `busy`=0, `done`=0, `overflow`=0;
  - `rd_data` undefined/don't-care;
  - sync flops 0.
- Reset mid-run: returns to IDLE at once, FIFO contents lost, `startIO` drops asynchronously.
- `go` sampled at edge k (IDLE): `startIO`=1 and `busy`=1 from edge k through edge k+START_CYCLES; state CAPTURE after edge k+START_CYCLES.
- `outFlag` first sampled high at edge n: s1 at n, s2 at n+1, rise valid after n+1, push at edge n+2. `count`/`empty` update after edge n+2.
- Pop at edge m: `count` and `rd_data` update after edge m.
- Timeout: DONE is entered after TIMEOUT consecutive CAPTURE cycles with no detected edge. `done` is registered from the state.
- All outputs are registered, except `rd_data`, `empty`, `full` and `count`, which are decoded from registered pointers and count.

## Test plan
- Reset: hold `reset`=0 mid-CAPTURE with 3 words stored → all outputs at reset values the same cycle; after release, `empty`=1, `count`=0, state IDLE.
- Launch (START_CYCLES=4): one-cycle `go` → `startIO` high exactly 4 cycles, `busy`=1, no `startIO` re-pulse when `go` is held high.
- Capture (TIMEOUT=50): `outFlag` pulses carrying 36'h000000001, 36'hABCDEF012, 36'hFFFFFFFFF, each high 10 cycles → `count`=3, reads return them in order, `empty`=1 after the 3rd pop; 50 idle cycles later `done`=1.
- Overflow (DEPTH=4): 6 pulses → `count`=4, `full`=1, `overflow`=1, first 4 words read back; next `go` in DONE clears `overflow` and `count`.
- Simultaneous: with `count`=2, a push and `rd_en` in the same cycle → `count` stays 2 and `rd_data` advances to the next word; with `full`=1 plus push and pop → `count`=DEPTH−1 and `overflow`=1.
- Edge gating: `outFlag` held high 200 cycles → exactly 1 push. A pulse during START or DONE → no push.
